// File: rtl/noc_mesh_router_if.sv
// noc_mesh_router_if: five req/ack/data lanes, one per router port (0=L 1=E 2=W 3=N 4=S).
// A transfer happens on a clock edge where req[p] and ack[p] are both high.
// master drives req/data and samples ack; slave samples req/data and drives ack.
interface noc_mesh_router_if #(
  parameter int PKT_W = 38
);
  logic [4:0]            req;
  logic [4:0]            ack;
  logic [4:0][PKT_W-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/noc_mesh_router.sv
// noc_mesh_router: 5-port buffered XY mesh router; per-input FIFOs, round-robin arbiter per output.
// Latency: 1 cycle from input accept to req on the output register when uncontended and the output is free.
// Backpressure: input ack drops while that input FIFO is full; output req/data hold until ack. NOC_ROUTER_STATS_EN adds counters.
module noc_mesh_router #(
  parameter int PAYLOAD    = 32,
  parameter int X_BITS     = 2,
  parameter int Y_BITS     = 2,
  parameter int X_CNT      = 3,
  parameter int Y_CNT      = 3,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  noc_mesh_router_if.slave  in_port,
  noc_mesh_router_if.master out_port
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [4:0][15:0]  stat_fwd_o,
  output logic [15:0]       stat_drop_o
`endif
);
  localparam int PKT = X_BITS + Y_BITS + 2 + PAYLOAD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0]     FULL  = CW'(FIFO_DEPTH);
  localparam logic [X_BITS:0]   X_LIM = (X_BITS + 1)'(X_CNT);
  localparam logic [Y_BITS:0]   Y_LIM = (Y_BITS + 1)'(Y_CNT);
  localparam logic [X_BITS-1:0] MY_X  = X_BITS'(SRC_X);
  localparam logic [Y_BITS-1:0] MY_Y  = Y_BITS'(SRC_Y);

  logic [PKT-1:0]        mem [5][FIFO_DEPTH];
  logic [4:0][AW-1:0]    rd_ptr;
  logic [4:0][AW-1:0]    wr_ptr;
  logic [4:0][CW-1:0]    count;
  logic [4:0][2:0]       rr_ptr;
  logic [PKT-1:0]        head [5];
  logic [4:0][X_BITS-1:0] dst_x;
  logic [4:0][Y_BITS-1:0] dst_y;
  logic [4:0]            not_full;
  logic [4:0]            push;
  logic [4:0]            pop;
  logic [4:0]            drop;
  logic [4:0]            out_free;
  logic [4:0][4:0]       route_req;   // [output][input]
  logic [4:0]            gnt_vld;
  logic [4:0][2:0]       gnt_idx;
  logic [3:0]            cand;

  // Input side: room in the FIFO, forced low while reset is held
  always_comb begin
    not_full = '0;
    for (int p = 0; p < 5; p++) begin
      not_full[p] = (count[p] != FULL);
    end
  end

  assign in_port.ack = not_full & {5{rst}};
  assign push        = in_port.req & in_port.ack;

  // Head decode: dimension-ordered route of each FIFO head, or drop if off-mesh
  always_comb begin
    route_req = '0;
    drop      = '0;
    dst_x     = '0;
    dst_y     = '0;
    for (int i = 0; i < 5; i++) begin
      head[i]  = mem[i][rd_ptr[i]];
      dst_x[i] = head[i][PKT-1 -: X_BITS];
      dst_y[i] = head[i][PKT-1-X_BITS -: Y_BITS];
      if (count[i] != '0) begin
        if (({1'b0, dst_x[i]} >= X_LIM) || ({1'b0, dst_y[i]} >= Y_LIM)) begin
          drop[i] = 1'b1;
        end else if (dst_x[i] > MY_X) begin
          route_req[1][i] = 1'b1;
        end else if (dst_x[i] < MY_X) begin
          route_req[2][i] = 1'b1;
        end else if (dst_y[i] > MY_Y) begin
          route_req[3][i] = 1'b1;
        end else if (dst_y[i] < MY_Y) begin
          route_req[4][i] = 1'b1;
        end else begin
          route_req[0][i] = 1'b1;
        end
      end
    end
  end

  // Per-output round-robin: first requester at/after rr_ptr, only when the output register can load
  always_comb begin
    gnt_vld  = '0;
    gnt_idx  = '0;
    out_free = '0;
    cand     = '0;
    pop      = drop;
    for (int o = 0; o < 5; o++) begin
      out_free[o] = ~out_port.req[o] | out_port.ack[o];
      for (int k = 0; k < 5; k++) begin
        cand = {1'b0, rr_ptr[o]} + 4'(k);
        if (cand >= 4'd5) begin
          cand = cand - 4'd5;
        end
        if (out_free[o] && !gnt_vld[o] && route_req[o][cand[2:0]]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand[2:0];
        end
      end
      // A head has exactly one route, so at most one output can pop a given input
      if (gnt_vld[o]) begin
        pop[gnt_idx[o]] = 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CW'(1);
        end else if (pop[i] && !push[i]) begin
          count[i] <= count[i] - CW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_port.data[i];
      end
    end
  end

  // Output registers and RR pointers; a held packet only leaves on its own handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_port.req  <= '0;
      out_port.data <= '0;
      rr_ptr        <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (out_free[o]) begin
          out_port.req[o] <= gnt_vld[o];
        end
        if (gnt_vld[o]) begin
          out_port.data[o] <= head[gnt_idx[o]];
          rr_ptr[o]        <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
        end
      end
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [2:0]  ndrop;
  logic [16:0] drop_sum;

  // Number of heads dropped this cycle (each input drops at most one)
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < 5; i++) begin
      ndrop = ndrop + {2'b00, drop[i]};
    end
    drop_sum = {1'b0, stat_drop_o} + {14'd0, ndrop};
  end

  // Saturating forward/drop counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fwd_o  <= '0;
      stat_drop_o <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (out_port.req[o] && out_port.ack[o] && (stat_fwd_o[o] != 16'hFFFF)) begin
          stat_fwd_o[o] <= stat_fwd_o[o] + 16'd1;
        end
      end
      stat_drop_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
